// File: rtl/button_conditioner.sv
// Push-button conditioner: per-channel 2-flop synchroniser and debounce FSM,
// plus a fixed-priority issuer that emits at most one single-cycle load strobe per cycle.
module button_conditioner #(
    parameter int N_BUTTONS       = 3,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [N_BUTTONS-1:0] i_buttons,
    output logic [N_BUTTONS-1:0] o_pulse,
    output logic [N_BUTTONS-1:0] o_level
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic [N_BUTTONS-1:0] sync1_p0;
    logic [N_BUTTONS-1:0] sync2_p1;
    state_t               state [N_BUTTONS];
    logic [CNT_W-1:0]     cnt   [N_BUTTONS];
    logic [N_BUTTONS-1:0] accept;
    logic [N_BUTTONS-1:0] pend;
    logic [N_BUTTONS-1:0] issue;

    function automatic logic [N_BUTTONS-1:0] lowest_set(input logic [N_BUTTONS-1:0] v);
        logic [N_BUTTONS-1:0] r;
        r = '0;
        for (int i = N_BUTTONS - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Stage p0/p1: metastability chain on the raw asynchronous inputs
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync1_p0 <= '0;
            sync2_p1 <= '0;
        end else begin
            sync1_p0 <= i_buttons;
            sync2_p1 <= sync1_p0;
        end
    end

    // Debounce: a level must hold for DEBOUNCE_CYCLES consecutive samples
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < N_BUTTONS; i++) begin
                state[i] <= RELEASED;
                cnt[i]   <= '0;
            end
            o_level <= '0;
        end else begin
            for (int i = 0; i < N_BUTTONS; i++) begin
                case (state[i])
                    RELEASED: begin
                        if (sync2_p1[i]) begin
                            state[i] <= PRESS_WAIT;
                            cnt[i]   <= CNT_ONE;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sync2_p1[i]) begin
                            state[i] <= RELEASED;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            state[i]   <= PRESSED;
                            cnt[i]     <= '0;
                            o_level[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_ONE;
                        end
                    end
                    PRESSED: begin
                        if (!sync2_p1[i]) begin
                            state[i] <= RELEASE_WAIT;
                            cnt[i]   <= CNT_ONE;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (sync2_p1[i]) begin
                            state[i] <= PRESSED;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            state[i]   <= RELEASED;
                            cnt[i]     <= '0;
                            o_level[i] <= 1'b0;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        state[i] <= RELEASED;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        accept = '0;
        for (int i = 0; i < N_BUTTONS; i++) begin
            accept[i] = (state[i] == PRESS_WAIT) && sync2_p1[i] && (cnt[i] == CNT_LAST);
        end
    end

    assign issue = lowest_set(pend);

    // Issue stage: a new acceptance wins over clearing the same pend bit
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pend    <= '0;
            o_pulse <= '0;
        end else begin
            pend    <= (pend & ~issue) | accept;
            o_pulse <= issue;
        end
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input conditioning stage that sits directly upstream of the ALU operand/opcode register bank: it takes the raw board push-buttons and turns each press into a clean single-cycle load strobe. Each button is synchronised, debounced and edge-detected. A fixed-priority issuer guarantees at most one strobe per cycle, so operand A, operand B and opcode loads never collide. The debounced levels are also exported for LEDs and status.

## Interface

Parameters:
- N_BUTTONS, 3: number of independent button channels.
- DEBOUNCE_CYCLES, 1000000: consecutive cycles a synchronised level must hold before it is accepted; legal range 2 to 2^24.

Ports:
- i_clk, input, 1: single system clock. All state is on its rising edge.
- i_reset, input, 1: reset, asynchronous and active-low. Assertion (0) clears all state immediately; release is synchronous to i_clk.
- i_buttons, input, N_BUTTONS: raw, asynchronous, bouncing button levels; 1 = pressed.
- o_pulse, output, N_BUTTONS: load strobes. One-hot or zero, high for exactly one cycle per accepted press.
- o_level, output, N_BUTTONS: debounced button levels.

## Operation

- **Synchroniser.** Each channel has a 2-flop chain, sync1 then sync2; only sync2 is used downstream.
- **Debounce FSM, one per channel.** States are RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT. The counter is ceil(log2(DEBOUNCE_CYCLES+1)) bits.
  - RELEASED: sync2=1 moves to PRESS_WAIT with cnt=1.
  - PRESS_WAIT:
    - sync2=0 returns to RELEASED with cnt=0 (glitch rejected).
    - Otherwise cnt increments.
    - When cnt=DEBOUNCE_CYCLES-1 and sync2=1, move to PRESSED, set level=1, set pend[i].
  - PRESSED: sync2=0 moves to RELEASE_WAIT with cnt=1.
  - RELEASE_WAIT:
    - sync2=1 returns to PRESSED with cnt=0.
    - When cnt=DEBOUNCE_CYCLES-1 and sync2=0, move to RELEASED and set level=0.
    - No pulse is generated on release.
- **Pending and issue.**
  - pend is an N_BUTTONS register.
  - Each edge: o_pulse <= one-hot of the lowest-index set bit of pend (zero if pend=0), and that bit is cleared.
  - Priority is fixed: button 0 > button 1 > button 2. This matches the A > B > opcode load order of the consumer.
  - Lower-priority requests are deferred, not dropped. Each waits one cycle per higher-priority bit ahead of it.
- **Arithmetic.** The counter never exceeds DEBOUNCE_CYCLES-1 and never wraps. The saturating compare is done against the constant.
- **Reset values.** o_pulse=0, o_level=0, pend=0, all FSMs in RELEASED, cnt=0, sync flops=0.

## Timing

- **Press latency.** Raw input rises and stays high before edge 1.
  - sync2=1 after edge 2.
  - FSM accepts at edge 2+DEBOUNCE_CYCLES; o_level=1 from then.
  - o_pulse is high for the cycle after edge 3+DEBOUNCE_CYCLES (no contention).
- **Release latency.** o_level falls 2+DEBOUNCE_CYCLES edges after the raw fall.
- **Glitch rejection.** Any high or low excursion of sync2 shorter than DEBOUNCE_CYCLES cycles leaves o_level and o_pulse unchanged.
- **Simultaneous acceptance.** k channels accepted on the same edge produce k pulses on k consecutive cycles, lowest index first.
- **pend set/clear collision.** If pend[i] is set and cleared on the same edge, the set wins. This case only arises from a new acceptance and never from the bit being issued.
- **Re-press while pending.** A re-press of a channel whose pend bit is still set merges into the single outstanding pulse. No count is kept.
- **Held button.** Holding a button produces exactly one pulse; no auto-repeat.
- **Button held through reset release.** The press is debounced from RELEASED and produces one pulse after the normal latency.
- **Reset mid-operation.** Debounce progress and pending pulses are discarded. o_pulse and o_level drop to 0 asynchronously on i_reset=0.

## Test plan

Bench uses N_BUTTONS=3, DEBOUNCE_CYCLES=4.

- **Clean press, button 0.** Raise i_buttons[0], hold 20 cycles, then drop.
  - o_level[0]=1 after edge 6; o_pulse=3'b001 for one cycle after edge 7.
  - o_level[0]=0 six edges after the drop; no further pulse.
- **Bounce.** On button 1, apply 1,0,1,1,0 (one cycle each), then hold 1.
  - No pulse during the bounce.
  - Exactly one o_pulse=3'b010, 7 edges after the start of the final stable high.
- **Simultaneous press.** Raise all three buttons on the same cycle.
  - o_pulse = 3'b001, 3'b010, 3'b100 on three consecutive cycles, then 0.
- **Held button.** Hold button 2 for 100 cycles.
  - One pulse only; o_level[2] stays high throughout.
- **Reset mid-operation.**
  - Assert i_reset=0 between acceptance and issue of button 1: o_pulse and o_level go to 0 immediately, and no pulse appears after release while the input is low.
  - Repeat with the input held high through release: exactly one pulse, 7 edges after reset release.
- **Short glitch.** Pulse sync2-equivalent input high for 3 cycles (less than 4), both from the released and from the pressed state.
  - o_level and o_pulse never change.
